// File: rtl/alu_multicycle.sv
// alu_multicycle: signed ALU with a valid/ready handshake on both sides.
//   add/sub/logic ops (and divide-by-zero) finish one cycle after accept;
//   mul/div/mod run a one-bit-per-cycle sequential datapath for WIDTH cycles.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid / in_ready    operation handshake (in_ready high only when idle)
//   reg1, reg2             signed operands
//   operation              opcode (add, sub, mul, div, mod, and, or, xor)
//   out_valid / out_ready  result handshake; result and flags held until taken
//   result                 signed result
//   z/n/v/c_flag           zero, negative, signed overflow, carry/borrow
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  input  logic [3:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z_flag,
  output logic             n_flag,
  output logic             v_flag,
  output logic             c_flag
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MOD = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;

  logic [1:0]       r_state;
  logic [3:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;   // sign of product / quotient
  logic             r_neg_r;   // sign of remainder (follows reg1)
  // Shared iteration registers:
  //   mul: {r_hi, r_lo} is the product shift register, r_m the multiplicand
  //   div: r_hi is the partial remainder, r_lo the dividend/quotient, r_m the divisor
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_m;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_slow;
  logic [WIDTH-1:0] w_fast_res;
  logic             w_fast_v;
  logic             w_fast_c;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_trial;
  logic [WIDTH-1:0] w_hi_n;
  logic [WIDTH-1:0] w_lo_n;

  logic [2*WIDTH-1:0] w_prod_mag;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_slow_res;
  logic               w_slow_v;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);

  assign w_sum   = {1'b0, reg1} + {1'b0, reg2};
  assign w_diff  = {1'b0, reg1} - {1'b0, reg2};
  // The most negative value maps to 2^(WIDTH-1), which is still exact unsigned.
  assign w_abs_a = reg1[WIDTH-1] ? (~reg1 + 1'b1) : reg1;
  assign w_abs_b = reg2[WIDTH-1] ? (~reg2 + 1'b1) : reg2;
  assign w_slow  = (operation == OP_MUL) ||
                   (((operation == OP_DIV) || (operation == OP_MOD)) && (reg2 != '0));

  // Single-cycle results; div/mod by zero and reserved opcodes fall to zero.
  always_comb begin
    w_fast_res = '0;
    w_fast_v   = 1'b0;
    w_fast_c   = 1'b0;
    case (operation)
      OP_ADD: begin
        w_fast_res = w_sum[WIDTH-1:0];
        w_fast_c   = w_sum[WIDTH];
        w_fast_v   = (reg1[WIDTH-1] == reg2[WIDTH-1]) && (w_sum[WIDTH-1] != reg1[WIDTH-1]);
      end
      OP_SUB: begin
        w_fast_res = w_diff[WIDTH-1:0];
        w_fast_c   = w_diff[WIDTH];
        w_fast_v   = (reg1[WIDTH-1] != reg2[WIDTH-1]) && (w_diff[WIDTH-1] != reg1[WIDTH-1]);
      end
      OP_AND:  w_fast_res = reg1 & reg2;
      OP_OR:   w_fast_res = reg1 | reg2;
      OP_XOR:  w_fast_res = reg1 ^ reg2;
      default: w_fast_res = '0;
    endcase
  end

  // One iteration step of shift-add multiply or restoring divide.
  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_m};

  always_comb begin
    w_hi_n = r_hi;
    w_lo_n = r_lo;
    if (r_op == OP_MUL) begin
      w_hi_n = w_mul_sum[WIDTH:1];
      w_lo_n = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end else if (!w_div_trial[WIDTH]) begin
      // Remainder is always below the divisor, so WIDTH bits hold it.
      w_hi_n = w_div_trial[WIDTH-1:0];
      w_lo_n = {r_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_hi_n = w_div_shift[WIDTH-1:0];
      w_lo_n = {r_lo[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix-up of the post-iteration values, used on the last CALC edge.
  assign w_prod_mag = {w_hi_n, w_lo_n};
  assign w_prod     = r_neg_q ? (~w_prod_mag + 1'b1) : w_prod_mag;

  always_comb begin
    w_slow_res = '0;
    w_slow_v   = 1'b0;
    case (r_op)
      OP_MUL: begin
        w_slow_res = w_prod[WIDTH-1:0];
        // Fits only if the upper half is a pure sign extension of bit WIDTH-1.
        w_slow_v   = !((&w_prod[2*WIDTH-1:WIDTH-1]) || !(|w_prod[2*WIDTH-1:WIDTH-1]));
      end
      OP_DIV: begin
        w_slow_res = r_neg_q ? (~w_lo_n + 1'b1) : w_lo_n;
        // Only -2^(WIDTH-1) / -1 yields a positive quotient with the MSB set.
        w_slow_v   = !r_neg_q && w_lo_n[WIDTH-1];
      end
      default: begin
        w_slow_res = r_neg_r ? (~w_hi_n + 1'b1) : w_hi_n;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_m     <= '0;
      result  <= '0;
      z_flag  <= 1'b0;
      n_flag  <= 1'b0;
      v_flag  <= 1'b0;
      c_flag  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op    <= operation;
            r_cnt   <= '0;
            r_neg_q <= reg1[WIDTH-1] ^ reg2[WIDTH-1];
            r_neg_r <= reg1[WIDTH-1];
            if (w_slow) begin
              r_state <= S_CALC;
              r_hi    <= '0;
              r_m     <= (operation == OP_MUL) ? w_abs_a : w_abs_b;
              r_lo    <= (operation == OP_MUL) ? w_abs_b : w_abs_a;
            end else begin
              r_state <= S_DONE;
              result  <= w_fast_res;
              z_flag  <= (w_fast_res == '0);
              n_flag  <= w_fast_res[WIDTH-1];
              v_flag  <= w_fast_v;
              c_flag  <= w_fast_c;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_n;
          r_lo  <= w_lo_n;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_DONE;
            result  <= w_slow_res;
            z_flag  <= (w_slow_res == '0);
            n_flag  <= w_slow_res[WIDTH-1];
            v_flag  <= w_slow_v;
            c_flag  <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
